// File: rtl/debug_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : debug_step_ctrl
// Purpose  : Debounced run/step command front-end for the clock-gating step
//            debugger. DEBUG_STEP_COUNT_EN builds the cumulative step counter.
// Revision : 1.0
// ============================================================================
module debug_step_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_CNT_W        = 16
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        run_btn,
  input  logic        step_btn,
  input  logic [2:0]  step_sw,
  output logic        debug_en,
  output logic        stepinto_en,
  output logic [2:0]  stepvalue,
  output logic        busy,
  output logic        step_done,
  output logic [15:0] total_steps
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0] btn_raw;
  logic [1:0] btn_lvl;
  logic [1:0] btn_press;

  // Bit 0 is the run button, bit 1 the step button.
  assign btn_raw = {step_btn, run_btn};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic [1:0]          sync_q;
    logic [DB_CNT_W-1:0] cnt_q;
    logic                lvl_q;
    logic                prev_q;

    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        sync_q <= 2'b00;
        cnt_q  <= '0;
        lvl_q  <= 1'b0;
        prev_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[0], btn_raw[i]};
        prev_q <= lvl_q;
        if (sync_q[1] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DB_LAST) begin
          cnt_q <= '0;
          lvl_q <= sync_q[1];
        end else begin
          cnt_q <= cnt_q + DB_CNT_W'(1);
        end
      end
    end

    assign btn_lvl[i]   = lvl_q;
    assign btn_press[i] = lvl_q & ~prev_q;
  end

  logic [2:0] sw_s1_q, sw_s2_q;
  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] stepvalue_q, stepvalue_d;
  logic       debug_en_q, debug_en_d;
  logic       stepinto_en_q, busy_q, step_done_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stepvalue_d = stepvalue_q;
    debug_en_d  = debug_en_q;
    case (state_q)
      S_IDLE: begin
        // A run press in the same cycle as a step press takes priority.
        if (btn_press[0]) begin
          debug_en_d = ~debug_en_q;
        end else if (btn_press[1] && debug_en_q && (sw_s2_q != 3'd0)) begin
          stepvalue_d = sw_s2_q;
          cnt_d       = sw_s2_q;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_HOLD;
      end
      S_HOLD: if (!btn_lvl[1]) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sw_s1_q       <= 3'd0;
      sw_s2_q       <= 3'd0;
      state_q       <= S_IDLE;
      cnt_q         <= 3'd0;
      stepvalue_q   <= 3'd0;
      debug_en_q    <= 1'b0;
      stepinto_en_q <= 1'b0;
      busy_q        <= 1'b0;
      step_done_q   <= 1'b0;
    end else begin
      sw_s1_q       <= step_sw;
      sw_s2_q       <= sw_s1_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stepvalue_q   <= stepvalue_d;
      debug_en_q    <= debug_en_d;
      stepinto_en_q <= (state_d == S_RUN) || (state_d == S_HOLD);
      busy_q        <= (state_d != S_IDLE);
      step_done_q   <= (state_q == S_RUN) && (state_d == S_HOLD);
    end
  end

  assign debug_en    = debug_en_q;
  assign stepinto_en = stepinto_en_q;
  assign stepvalue   = stepvalue_q;
  assign busy        = busy_q;
  assign step_done   = step_done_q;

`ifdef DEBUG_STEP_COUNT_EN
  logic [15:0] total_q;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      total_q <= 16'd0;
    end else if (step_done_q) begin
      total_q <= total_q + {13'd0, stepvalue_q};
    end
  end

  assign total_steps = total_q;
`else
  assign total_steps = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debug_step_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_step_ctrl
// Purpose  : Randomized self-checking bench for debug_step_ctrl with a
//            burst-level reference model and a downstream step-counter model.
// Revision : 1.0
// ============================================================================
module tb_debug_step_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic        run_btn;
  logic        step_btn;
  logic [2:0]  step_sw;
  logic        debug_en;
  logic        stepinto_en;
  logic [2:0]  stepvalue;
  logic        busy;
  logic        step_done;
  logic [15:0] total_steps;

  int          total_cnt = 0;
  int          bad_cnt   = 0;
  logic [15:0] model_total = 16'd0;
  int          ds_cnt = 0;
  int          gated  = 0;

  debug_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (16)
  ) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .step_sw    (step_sw),
    .debug_en   (debug_en),
    .stepinto_en(stepinto_en),
    .stepvalue  (stepvalue),
    .busy       (busy),
    .step_done  (step_done),
    .total_steps(total_steps)
  );

  always #5 clk_in = ~clk_in;

  // Downstream stage: loads when stepinto_en=0, emits one gated clock per
  // cycle while enabled and its count is non-zero.
  always @(negedge clk_in) begin
    if (!stepinto_en) ds_cnt = int'(stepvalue);
    else if (ds_cnt > 0) begin
      ds_cnt = ds_cnt - 1;
      gated  = gated + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk_in);
  endtask

  function automatic logic [15:0] exp_total();
`ifdef DEBUG_STEP_COUNT_EN
    return model_total;
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; run_btn = 1'b0; step_btn = 1'b0; step_sw = 3'd0;
    cyc(3);
    total_cnt++; if ({debug_en, stepinto_en, busy, step_done} !== 4'b0000) begin
      bad_cnt++; $display("FAIL reset_ctrl: got %b want 0000", {debug_en, stepinto_en, busy, step_done});
    end
    total_cnt++; if (stepvalue !== 3'd0) begin
      bad_cnt++; $display("FAIL reset_stepvalue: got %0d want 0", stepvalue);
    end
    total_cnt++; if (total_steps !== 16'd0) begin
      bad_cnt++; $display("FAIL reset_total: got %0d want 0", total_steps);
    end
    rst_n = 1'b1;
    model_total = 16'd0;
    cyc(2);
  endtask

  task automatic toggle_run(input logic want);
    int   changes;
    logic prev;
    logic busy_seen;
    changes = 0; prev = debug_en; busy_seen = 1'b0;
    run_btn = 1'b1;
    repeat (10) begin
      cyc();
      if (debug_en !== prev) begin changes++; prev = debug_en; end
      busy_seen |= busy;
    end
    run_btn = 1'b0;
    repeat (20) begin
      cyc();
      if (debug_en !== prev) begin changes++; prev = debug_en; end
      busy_seen |= busy;
    end
    total_cnt++; if (debug_en !== want) begin
      bad_cnt++; $display("FAIL run_toggle_level: got %b want %b", debug_en, want);
    end
    total_cnt++; if (changes != 1) begin
      bad_cnt++; $display("FAIL run_toggle_count: got %0d toggles want 1", changes);
    end
    total_cnt++; if (busy_seen !== 1'b0) begin
      bad_cnt++; $display("FAIL run_toggle_busy: got %b want 0", busy_seen);
    end
  endtask

  task automatic run_burst(input int n, input int extra_hold);
    int   waitc, runc, g0;
    logic hold_err;
    step_sw = 3'(n);
    cyc(4);
    g0 = gated;
    step_btn = 1'b1;
    waitc = 0;
    while (!busy && waitc < 30) begin cyc(); waitc++; end
    total_cnt++; if (busy !== 1'b1) begin
      bad_cnt++; $display("FAIL burst_start n=%0d: busy got %b want 1", n, busy);
    end
    total_cnt++; if (stepinto_en !== 1'b0 || stepvalue !== 3'(n)) begin
      bad_cnt++; $display("FAIL burst_load n=%0d: stepinto_en=%b stepvalue=%0d want 0/%0d", n, stepinto_en, stepvalue, n);
    end
    runc = 0;
    cyc();
    while (step_done !== 1'b1 && runc < 12) begin
      if (stepinto_en) runc++;
      cyc();
    end
    total_cnt++; if (runc != n) begin
      bad_cnt++; $display("FAIL burst_run_len: got %0d cycles want %0d", runc, n);
    end
    total_cnt++; if (step_done !== 1'b1 || stepinto_en !== 1'b1) begin
      bad_cnt++; $display("FAIL burst_done: step_done=%b stepinto_en=%b want 1/1", step_done, stepinto_en);
    end
    hold_err = 1'b0;
    repeat (extra_hold + 1) begin
      cyc();
      if (step_done !== 1'b0 || busy !== 1'b1 || stepinto_en !== 1'b1) hold_err = 1'b1;
    end
    total_cnt++; if (hold_err !== 1'b0) begin
      bad_cnt++; $display("FAIL burst_hold n=%0d: got err=%b want 0", n, hold_err);
    end
    step_btn = 1'b0;
    waitc = 0;
    while (busy && waitc < 20) begin cyc(); waitc++; end
    total_cnt++; if (busy !== 1'b0 || stepinto_en !== 1'b0) begin
      bad_cnt++; $display("FAIL burst_idle: busy=%b stepinto_en=%b want 0/0", busy, stepinto_en);
    end
    model_total = model_total + 16'(n);
    cyc(3);
    total_cnt++; if (gated - g0 != n) begin
      bad_cnt++; $display("FAIL burst_gated: got %0d clocks want %0d", gated - g0, n);
    end
    total_cnt++; if (total_steps !== exp_total()) begin
      bad_cnt++; $display("FAIL burst_total: got %0d want %0d", total_steps, exp_total());
    end
  endtask

  task automatic test_run_toggle();
    toggle_run(1'b1);
    toggle_run(1'b0);
    toggle_run(1'b1);
  endtask

  task automatic test_total();
    run_burst(7, 0);
    run_burst(5, 2);
    run_burst(2, 1);
    total_cnt++;
`ifdef DEBUG_STEP_COUNT_EN
    if (total_steps !== 16'd14) begin
      bad_cnt++; $display("FAIL total_14: got %0d want 14", total_steps);
    end
`else
    if (total_steps !== 16'd0) begin
      bad_cnt++; $display("FAIL total_off: got %0d want 0", total_steps);
    end
`endif
  endtask

  task automatic test_step_burst();
    run_burst(3, 8);
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int   rises, dones, g0;
    logic prev_busy;
    pat = 8'b0011_0011;
    step_sw = 3'd4;
    cyc(4);
    g0 = gated; rises = 0; dones = 0; prev_busy = busy;
    for (int i = 0; i < 8; i++) begin
      step_btn = pat[i];
      cyc();
      if (busy && !prev_busy) rises++;
      if (step_done) dones++;
      prev_busy = busy;
    end
    step_btn = 1'b1;
    repeat (40) begin
      cyc();
      if (busy && !prev_busy) rises++;
      if (step_done) dones++;
      prev_busy = busy;
    end
    step_btn = 1'b0;
    repeat (20) begin
      cyc();
      if (busy && !prev_busy) rises++;
      if (step_done) dones++;
      prev_busy = busy;
    end
    model_total = model_total + 16'd4;
    total_cnt++; if (rises != 1 || dones != 1) begin
      bad_cnt++; $display("FAIL bounce_bursts: got %0d bursts %0d dones want 1/1", rises, dones);
    end
    total_cnt++; if (gated - g0 != 4) begin
      bad_cnt++; $display("FAIL bounce_gated: got %0d want 4", gated - g0);
    end
    total_cnt++; if (total_steps !== exp_total()) begin
      bad_cnt++; $display("FAIL bounce_total: got %0d want %0d", total_steps, exp_total());
    end
  endtask

  task automatic test_ignored();
    logic active;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        toggle_run(1'b0);
        step_sw = 3'd5;
      end else begin
        toggle_run(1'b1);
        step_sw = 3'd0;
      end
      cyc(4);
      active = 1'b0;
      step_btn = 1'b1;
      repeat (15) begin cyc(); active |= busy | stepinto_en | step_done; end
      step_btn = 1'b0;
      repeat (15) begin cyc(); active |= busy | stepinto_en | step_done; end
      total_cnt++; if (active !== 1'b0) begin
        bad_cnt++; $display("FAIL ignored_case%0d: activity got %b want 0", k, active);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic active;
    step_sw = 3'd6;
    cyc(4);
    active = 1'b0;
    run_btn = 1'b1; step_btn = 1'b1;
    repeat (10) begin cyc(); active |= busy | step_done; end
    run_btn = 1'b0; step_btn = 1'b0;
    repeat (20) begin cyc(); active |= busy | step_done; end
    total_cnt++; if (debug_en !== 1'b0) begin
      bad_cnt++; $display("FAIL simul_debug_en: got %b want 0", debug_en);
    end
    total_cnt++; if (active !== 1'b0) begin
      bad_cnt++; $display("FAIL simul_burst: activity got %b want 0", active);
    end
    toggle_run(1'b1);
  endtask

  task automatic test_random_bursts();
    for (int i = 0; i < 6; i++) begin
      run_burst(int'($urandom_range(1, 7)), int'($urandom_range(0, 5)));
    end
  endtask

  task automatic test_reset_mid_run();
    int waitc;
    step_sw = 3'd7;
    cyc(4);
    step_btn = 1'b1;
    waitc = 0;
    while (!stepinto_en && waitc < 30) begin cyc(); waitc++; end
    cyc(2);
    total_cnt++; if (busy !== 1'b1 || stepinto_en !== 1'b1) begin
      bad_cnt++; $display("FAIL midrun_pre: busy=%b stepinto_en=%b want 1/1", busy, stepinto_en);
    end
    rst_n = 1'b0; step_btn = 1'b0;
    cyc();
    model_total = 16'd0;
    total_cnt++; if ({debug_en, stepinto_en, busy, step_done, stepvalue} !== 7'd0) begin
      bad_cnt++; $display("FAIL midrun_reset: got %b want 0000000", {debug_en, stepinto_en, busy, step_done, stepvalue});
    end
    total_cnt++; if (total_steps !== 16'd0) begin
      bad_cnt++; $display("FAIL midrun_total: got %0d want 0", total_steps);
    end
    rst_n = 1'b1;
    cyc(10);
    total_cnt++; if (busy !== 1'b0 || debug_en !== 1'b0) begin
      bad_cnt++; $display("FAIL midrun_after: busy=%b debug_en=%b want 0/0", busy, debug_en);
    end
  endtask

  initial begin
    test_reset();
    test_run_toggle();
    test_total();
    test_step_burst();
    test_bounce();
    test_ignored();
    test_simultaneous();
    test_random_bursts();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/debug_step_ctrl.md
Name: debug_step_ctrl

Overview:
- Command front-end that sits directly upstream of the clock-gating step debugger.
- Converts raw board inputs (run/halt button, step button, 3-bit step-count switches) into that stage's control signals: debug_en, stepinto_en and stepvalue.
- Debounces the buttons, toggles debug mode, and sequences a load-then-step burst so the downstream stage emits exactly N gated clocks per step press.
- Runs on the free-running board clock clk_in, never on the gated clock.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable synchronized samples required before a debounced button level changes.
- DB_CNT_W, 16: debounce counter width. Must hold DEBOUNCE_CYCLES.

Ports:
- clk_in  input  1  free-running system clock; all logic on posedge.
- rst_n  input  1  reset; synchronous, active-low.
- run_btn  input  1  raw asynchronous run/halt button, active-high.
- step_btn  input  1  raw asynchronous step button, active-high.
- step_sw  input  3  raw step-count switches, value 0..7.
- debug_en  output  1  to downstream; 1 = halted/step mode.
- stepinto_en  output  1  to downstream; 0 = load count, 1 = consume count.
- stepvalue  output  3  to downstream; step count for the burst.
- busy  output  1  high in LOAD, RUN, HOLD.
- step_done  output  1  one-cycle pulse when a burst completes.
- total_steps  output  16  cumulative steps issued (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a posedge):
  - debug_en=0, stepinto_en=0, stepvalue=0, busy=0, step_done=0, total_steps=0.
  - State=IDLE; synchronizers, debounced levels and counters cleared.
  - Reset mid-burst aborts immediately; the downstream stage reloads because stepinto_en=0.
- Inputs:
  - run_btn and step_btn each pass a 2-FF synchronizer.
  - step_sw is 2-FF synchronized, no debounce.
- Debounce, per button:
  - Counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - At count == DEBOUNCE_CYCLES-1 the debounced level flips and the counter clears.
  - A registered rising-edge detect on the debounced level gives a one-cycle press event.
- All outputs are registered.
- FSM states: IDLE, LOAD, RUN, HOLD.
- IDLE:
  - stepinto_en=0, busy=0.
  - run press toggles debug_en.
  - step press with debug_en=1 and synced step_sw!=0: stepvalue<=step_sw, step counter<=step_sw, go to LOAD.
  - step press with debug_en=0 or step_sw==0: ignored, no pulse.
  - Simultaneous run and step press in the same cycle: run wins, step dropped.
- LOAD, exactly 1 cycle:
  - stepinto_en=0 so the downstream stage samples stepvalue.
  - Next state RUN.
- RUN:
  - stepinto_en=1.
  - Step counter decrements each cycle.
  - When counter==1, next state HOLD; RUN lasts exactly stepvalue cycles.
- HOLD:
  - stepinto_en stays 1, holding the downstream count at 0.
  - step_done pulses on the first HOLD cycle only.
  - Return to IDLE when the debounced step level is 0.
  - Holding the button never retriggers.
- Press events outside IDLE are ignored, so debug_en never changes mid-burst.
- stepvalue holds its last value in IDLE; a new value is latched only on an accepted press.
- Step counter is 3-bit with no wrap; the value 0 never enters RUN.

Optional Feature:
- Macro: DEBUG_STEP_COUNT_EN.
- Defined:
  - total_steps is a 16-bit register that adds stepvalue on each step_done pulse.
  - Wraps modulo 2^16.
  - Cleared by reset only.
- Undefined: total_steps is tied to 16'd0 and no counter logic is built.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then run_btn pulse of 10 cycles -> debug_en 0->1 once after synchronizer plus debounce latency; a second pulse -> back to 0.
- debug_en=1, step_sw=3, step_btn held 20 cycles -> one LOAD cycle with stepinto_en=0 and stepvalue=3, then stepinto_en=1 for 3 RUN cycles, step_done=1 for 1 cycle, HOLD until release, then IDLE; the downstream model emits exactly 3 gated clocks.
- step_btn bouncing 1-0-1 with 2-cycle glitches, then stable -> exactly one burst.
- debug_en=0 step press, or debug_en=1 with step_sw=0 -> state stays IDLE, stepinto_en stays 0, no step_done.
- rst_n low for 1 cycle during RUN with stepvalue=7 -> all outputs at reset values on the next cycle; total_steps=0.
- With DEBUG_STEP_COUNT_EN: bursts of 7, 5 and 2 -> total_steps=14. Without the macro -> total_steps=0 throughout.
